// File: rtl/oneshot_pulse_pkg.sv
// Shared constants and helpers for the one-shot pulse generator.
package oneshot_pulse_pkg;

  // Trigger edge selection codes; any other value falls back to rising.
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_BOTH    = 2;

  // Level of the synced input that counts as "active" for hold mode.
  // Only a falling-edge configuration treats a low input as active.
  function automatic logic active_level(input int edge_sel);
    return (edge_sel == EDGE_FALLING) ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/oneshot_pulse_edge_sync.sv
// Two-flop input synchronizer, previous-sample flop and trigger-edge select.
module oneshot_edge_sync
  import oneshot_pulse_pkg::*;
#(
  parameter int EDGE = EDGE_RISING
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_din,
  output logic o_trig,
  output logic o_level
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic w_rise;
  logic w_fall;
  logic w_both;

  // Synchronize the raw input and keep the previous synced sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_din;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;
  assign w_both = r_s2 ^ r_s3;

  // Pick the configured edge; unknown codes behave as rising.
  always_comb begin
    o_trig = w_rise;
    case (EDGE)
      EDGE_FALLING: o_trig = w_fall;
      EDGE_BOTH:    o_trig = w_both;
      default:      o_trig = w_rise;
    endcase
  end

  assign o_level = r_s2;

endmodule

// File: rtl/oneshot_pulse.sv
// Monostable pulse generator: turns a trigger edge on an asynchronous input
// into a registered pulse of PULSE_LEN clock cycles, with optional retrigger
// and hold-while-active behaviour.
module oneshot_pulse
  import oneshot_pulse_pkg::*;
#(
  parameter int PULSE_LEN = 1,
  parameter int RETRIGGER = 0,
  parameter int HOLD      = 0,
  parameter int EDGE      = EDGE_RISING
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_din,
  output logic o_dout
);

  localparam int               CNT_W    = $clog2(PULSE_LEN + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PULSE_LEN);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic             ACT_LVL  = active_level(EDGE);

  logic             w_trig;
  logic             w_level;
  logic             w_hold;
  logic             w_load;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dout;

  oneshot_edge_sync #(
    .EDGE (EDGE)
  ) u_edge_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_din   (i_din),
    .o_trig  (w_trig),
    .o_level (w_level)
  );

  // Hold keeps reloading regardless of RETRIGGER; otherwise a trigger only
  // reloads when idle or when retriggering is enabled.
  assign w_hold = (HOLD != 0) && (w_level == ACT_LVL);
  assign w_load = w_hold || (w_trig && ((r_cnt == '0) || (RETRIGGER != 0)));

  // Down-counter with registered output; dout drops on the edge cnt leaves 1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_dout <= 1'b0;
    end else if (w_load) begin
      r_cnt  <= LOAD_VAL;
      r_dout <= 1'b1;
    end else if (r_cnt != '0) begin
      r_cnt  <= r_cnt - ONE;
      r_dout <= (r_cnt > ONE);
    end
  end

  assign o_dout = r_dout;

endmodule

// File: tb/tb_oneshot_pulse.sv
// Directed bench for oneshot_pulse: several configurations share one clock,
// reset and input; each phase records every output per cycle and checks
// pulse position, length and count against hand-derived values.
//
// Timing reference: din is set before the edge that produces record 0, so
// s1 captures it at record 0, s2 at record 1 and dout is first high at
// record 2. A fall of din before record k gives a falling trigger whose
// dout pulse starts at record k+2.
module tb_oneshot_pulse;

  logic       clk;
  logic       rst;
  logic       din;
  logic [7:0] dout_bus;

  int checks;
  int failures;

  logic [7:0] hist [0:399];
  int nrec;

  // u0: PL=60 non-retrig   u1: PL=60 retrig      u2: PL=1 hold
  // u3: PL=1 rising        u4: PL=1 both edges   u5: PL=1 falling
  // u6: PL=4 non-retrig    u7: PL=1 EDGE=3 (acts as rising)
  oneshot_pulse #(.PULSE_LEN(60), .RETRIGGER(0), .HOLD(0), .EDGE(0)) u0 (
    .i_clk(clk), .i_rst(rst), .i_din(din), .o_dout(dout_bus[0]));
  oneshot_pulse #(.PULSE_LEN(60), .RETRIGGER(1), .HOLD(0), .EDGE(0)) u1 (
    .i_clk(clk), .i_rst(rst), .i_din(din), .o_dout(dout_bus[1]));
  oneshot_pulse #(.PULSE_LEN(1), .RETRIGGER(0), .HOLD(1), .EDGE(0)) u2 (
    .i_clk(clk), .i_rst(rst), .i_din(din), .o_dout(dout_bus[2]));
  oneshot_pulse #(.PULSE_LEN(1), .RETRIGGER(0), .HOLD(0), .EDGE(0)) u3 (
    .i_clk(clk), .i_rst(rst), .i_din(din), .o_dout(dout_bus[3]));
  oneshot_pulse #(.PULSE_LEN(1), .RETRIGGER(0), .HOLD(0), .EDGE(2)) u4 (
    .i_clk(clk), .i_rst(rst), .i_din(din), .o_dout(dout_bus[4]));
  oneshot_pulse #(.PULSE_LEN(1), .RETRIGGER(0), .HOLD(0), .EDGE(1)) u5 (
    .i_clk(clk), .i_rst(rst), .i_din(din), .o_dout(dout_bus[5]));
  oneshot_pulse #(.PULSE_LEN(4), .RETRIGGER(0), .HOLD(0), .EDGE(0)) u6 (
    .i_clk(clk), .i_rst(rst), .i_din(din), .o_dout(dout_bus[6]));
  oneshot_pulse #(.PULSE_LEN(1), .RETRIGGER(0), .HOLD(0), .EDGE(3)) u7 (
    .i_clk(clk), .i_rst(rst), .i_din(din), .o_dout(dout_bus[7]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle and record all outputs 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (nrec < 400) begin
      hist[nrec] = dout_bus;
      nrec++;
    end
  endtask

  task automatic phase_start(input logic din_v);
    din = din_v;
    rst = 1'b1;
    cyc();
    cyc();
    chk("reset_state", int'(dout_bus), 0);
    rst = 1'b0;
    nrec = 0;
  endtask

  function automatic int first_high(input int b);
    for (int i = 0; i < nrec; i++) if (hist[i][b]) return i;
    return -1;
  endfunction

  function automatic int n_high(input int b, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i < hi; i++) if (hist[i][b]) n++;
    return n;
  endfunction

  function automatic int n_pulses(input int b);
    int n = 0;
    logic prev = 1'b0;
    for (int i = 0; i < nrec; i++) begin
      if (hist[i][b] && !prev) n++;
      prev = hist[i][b];
    end
    return n;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    nrec     = 0;
    rst      = 1'b1;
    din      = 1'b0;

    // A: din high 5 cycles.
    phase_start(1'b0);
    din = 1'b1;
    repeat (5) cyc();
    din = 1'b0;
    repeat (80) cyc();
    chk("A_u0_first", first_high(0), 2);
    chk("A_u0_len", n_high(0, 0, nrec), 60);
    chk("A_u0_pulses", n_pulses(0), 1);
    chk("A_u6_len", n_high(6, 0, nrec), 4);
    chk("A_u3_first", first_high(3), 2);
    chk("A_u3_len", n_high(3, 0, nrec), 1);
    chk("A_u7_first", first_high(7), 2);
    chk("A_u7_len", n_high(7, 0, nrec), 1);
    chk("A_u5_first", first_high(5), 7);
    chk("A_u5_len", n_high(5, 0, nrec), 1);
    chk("A_u4_pulses", n_pulses(4), 2);
    chk("A_u4_second", int'(hist[7][4]), 1);
    // Hold PL=1: s2 high recs 1..5, sampled high on edges 2..6, fall at 7.
    chk("A_u2_first", first_high(2), 2);
    chk("A_u2_len", n_high(2, 0, nrec), 5);

    // B: din high 95 cycles; hold gives 95 + PULSE_LEN - 1 high cycles.
    phase_start(1'b0);
    din = 1'b1;
    repeat (95) cyc();
    din = 1'b0;
    repeat (10) cyc();
    chk("B_u2_len", n_high(2, 0, nrec), 95);
    chk("B_u2_pulses", n_pulses(2), 1);
    chk("B_u2_last", int'(hist[96][2]), 1);
    chk("B_u2_off", int'(hist[97][2]), 0);
    chk("B_u3_len", n_high(3, 0, nrec), 1);

    // C: din high 15 cycles; both-edge pulses 15 apart, falling only second.
    phase_start(1'b0);
    din = 1'b1;
    repeat (15) cyc();
    din = 1'b0;
    repeat (10) cyc();
    chk("C_u4_p1", int'(hist[2][4]), 1);
    chk("C_u4_p2", int'(hist[17][4]), 1);
    chk("C_u4_len", n_high(4, 0, nrec), 2);
    chk("C_u5_first", first_high(5), 17);
    chk("C_u5_len", n_high(5, 0, nrec), 1);

    // D: rising edges at 0, 35, 70 (din high 2 cycles each).
    phase_start(1'b0);
    for (int i = 0; i < 200; i++) begin
      din = (i < 72) && ((i % 35) < 2);
      cyc();
    end
    chk("D_u1_first", first_high(1), 2);
    chk("D_u1_len", n_high(1, 0, nrec), 130);
    chk("D_u1_pulses", n_pulses(1), 1);
    chk("D_u0_pulses", n_pulses(0), 2);
    chk("D_u0_len", n_high(0, 0, nrec), 120);
    chk("D_u0_gap", n_high(0, 62, 72), 0);
    chk("D_u0_second", first_high(0) + 70, 72);
    chk("D_u0_p2", int'(hist[72][0]), 1);

    // E: PL=4 non-retrig, second 1-cycle trigger at offset 3, 4, 5.
    for (int s = 3; s <= 5; s++) begin
      phase_start(1'b0);
      for (int i = 0; i < 20; i++) begin
        din = (i == 0) || (i == s);
        cyc();
      end
      chk($sformatf("E%0d_u6_pulses", s), n_pulses(6), (s == 5) ? 2 : 1);
      chk($sformatf("E%0d_u6_len", s), n_high(6, 0, nrec), (s == 5) ? 8 : 4);
      if (s == 5) begin
        chk("E5_u6_gap", int'(hist[6][6]), 0);
        chk("E5_u6_restart", int'(hist[7][6]), 1);
      end
    end

    // F: reset mid-pulse at pulse cycle 20, din static low afterwards.
    phase_start(1'b0);
    for (int i = 0; i < 22; i++) begin
      din = (i < 5);
      cyc();
    end
    chk("F_u0_before", int'(hist[21][0]), 1);
    rst = 1'b1;
    cyc();
    chk("F_u0_reset", int'(hist[22][0]), 0);
    rst = 1'b0;
    repeat (70) cyc();
    chk("F_u0_quiet", n_high(0, 22, nrec), 0);

    // G: din held high through reset; release looks like a rising edge.
    phase_start(1'b1);
    repeat (80) cyc();
    chk("G_u0_first", first_high(0), 2);
    chk("G_u0_len", n_high(0, 0, nrec), 60);
    chk("G_u0_pulses", n_pulses(0), 1);
    chk("G_u4_first", first_high(4), 2);
    chk("G_u5_none", n_high(5, 0, nrec), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
